// File: rtl/led_pkg.sv
// Shared widths and button index constants for the LED counter board.
// Every file of this block imports it.
package led_pkg;

  localparam int NUM_BTN   = 4;
  localparam int LED_W     = 4;

  localparam int BTN_INC   = 0;
  localparam int BTN_DEC   = 1;
  localparam int BTN_CLR   = 2;
  localparam int BTN_BLINK = 3;

  typedef logic [LED_W-1:0] led_t;

endpackage

// File: rtl/btn_debounce.sv
// Takes one raw push button through a synchronizer, a level debouncer and a
// rising-edge detector, producing a single-cycle press pulse.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 2
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          db_q, db_d;
  logic          db_dly_q, db_dly_d;
  logic [CW-1:0] dbcnt_q, dbcnt_d;

  // The debounced level only moves once s2 has disagreed with it for DB_CYCLES clocks in a row.
  always_comb begin
    s1_d     = btn;
    s2_d     = s1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    dbcnt_d  = dbcnt_q;
    if (s2_q == db_q) begin
      dbcnt_d = '0;
    end else if (dbcnt_q == DB_LAST) begin
      db_d    = s2_q;
      dbcnt_d = '0;
    end else begin
      dbcnt_d = dbcnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      dbcnt_q  <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      dbcnt_q  <= dbcnt_d;
    end
  end

  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/led_top.sv
// Four-button LED counter: increment, decrement, clear and blink toggle,
// with the counter value shown on the LEDs, optionally blinking.
module led_top
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 2,
  parameter int BLINK_DIV = 4
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [LED_W-1:0]   led
);

  localparam int            PW        = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(BLINK_DIV - 1);

  logic               rst_meta_q;
  logic               rst_sync_q;
  logic [NUM_BTN-1:0] press;
  led_t               cnt_q, cnt_d;
  logic               blink_en_q, blink_en_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               phase_q, phase_d;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
      .sclk  (sclk),
      .rst_n (rst_sync_q),
      .btn   (btn[i]),
      .press (press[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (press[BTN_CLR]) begin
      cnt_d = '0;
    end else if (press[BTN_INC] && press[BTN_DEC]) begin
      cnt_d = cnt_q;
    end else if (press[BTN_INC]) begin
      cnt_d = cnt_q + 1'b1;
    end else if (press[BTN_DEC]) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // The prescaler stays at zero on the enabling edge so the first dark half-period is full length.
  always_comb begin
    blink_en_d = blink_en_q ^ press[BTN_BLINK];
    presc_d    = presc_q;
    phase_d    = phase_q;
    if (!blink_en_q || !blink_en_d) begin
      presc_d = '0;
      phase_d = 1'b0;
    end else if (presc_q == PRESC_TOP) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      cnt_q      <= '0;
      blink_en_q <= 1'b0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      blink_en_q <= blink_en_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
    end
  end

  assign led = (!blink_en_q || phase_q) ? cnt_q : '0;

endmodule

// File: tb/tb_led_top.sv
// Directed bench for led_top at default parameters: a vector table for the
// counter priorities plus hand-written sequences for timing, blink and reset.
module tb_led_top;

  logic       sclk;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] led;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs [14];

  led_top #(
    .DB_CYCLES (2),
    .BLINK_DIV (4)
  ) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .btn   (btn),
    .led   (led)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [3:0] exp);
    n_cmp++;
    if (led !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: led=%b expected=%b at %0t", name, led, exp, $time);
    end
  endtask

  // Drive a button pattern for 'hold' sampled edges, release it, then let everything settle.
  task automatic applyStimulus(input logic [3:0] b, input int hold);
    @(negedge sclk);
    btn = b;
    repeat (hold) @(posedge sclk);
    @(negedge sclk);
    btn = 4'b0000;
    repeat (10) @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic doReset();
    @(negedge sclk);
    rst_n = 1'b0;
    btn   = 4'b0000;
    repeat (3) @(posedge sclk);
    #1;
    checkOutput("reset_led", 4'b0000);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (6) @(posedge sclk);
    @(negedge sclk);
  endtask

  // 23 ns pulse started 2 ns after an edge: sampled by exactly two edges.
  task automatic shortPulseInc(input logic [3:0] old_led, input logic [3:0] new_led, input string name);
    @(posedge sclk);
    #2;
    btn = 4'b0001;
    @(posedge sclk);
    @(posedge sclk);
    #5;
    btn = 4'b0000;
    @(posedge sclk);
    @(posedge sclk);
    #1;
    checkOutput({name, "_edge4"}, old_led);
    @(posedge sclk);
    #1;
    checkOutput({name, "_edge5"}, new_led);
    repeat (10) @(posedge sclk);
  endtask

  initial begin
    logic [3:0] exp;
    bit         found;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    btn   = 4'b0000;

    vecs[0]  = '{4'b0010, 3, 4'hF};
    vecs[1]  = '{4'b0001, 3, 4'h0};
    vecs[2]  = '{4'b0001, 3, 4'h1};
    vecs[3]  = '{4'b0001, 3, 4'h2};
    vecs[4]  = '{4'b0001, 3, 4'h3};
    vecs[5]  = '{4'b0001, 3, 4'h4};
    vecs[6]  = '{4'b0001, 3, 4'h5};
    vecs[7]  = '{4'b0011, 3, 4'h5};
    vecs[8]  = '{4'b0101, 3, 4'h0};
    vecs[9]  = '{4'b0001, 1, 4'h0};
    vecs[10] = '{4'b0001, 2, 4'h1};
    vecs[11] = '{4'b0010, 3, 4'h0};
    vecs[12] = '{4'b0110, 3, 4'h0};
    vecs[13] = '{4'b0111, 4, 4'h0};

    $display("[TB] start");
    doReset();

    shortPulseInc(4'h0, 4'h1, "pulse1");
    shortPulseInc(4'h1, 4'h2, "pulse2");
    shortPulseInc(4'h2, 4'h3, "pulse3");

    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].hold);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_led);
    end

    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 3);
    checkOutput("cnt_three", 4'h3);

    // Blink on: press pulse after edge 4, blink_en set at edge 5, dark for 4 clocks then lit for 4.
    @(negedge sclk);
    btn = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sclk);
      #1;
      if (k == 3) btn = 4'b0000;
      if (k >= 5) begin
        exp = ((((k - 5) / 4) % 2) == 1) ? 4'b0011 : 4'b0000;
        checkOutput($sformatf("blink_k%0d", k), exp);
      end
    end

    applyStimulus(4'b1000, 3);
    for (int k = 0; k < 10; k++) begin
      @(posedge sclk);
      #1;
      checkOutput($sformatf("blink_off_k%0d", k), 4'b0011);
    end

    @(negedge sclk);
    btn = 4'b0001;
    repeat (200) @(posedge sclk);
    #1;
    checkOutput("held_200", 4'h4);
    @(negedge sclk);
    btn = 4'b0000;
    repeat (10) @(posedge sclk);
    #1;
    checkOutput("held_release", 4'h4);

    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 3);
    checkOutput("cnt_seven", 4'h7);
    applyStimulus(4'b1000, 3);

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge sclk);
      #1;
      if (led == 4'h7) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("[TB] FAIL blink_lit_wait: led never showed %b within 20 clocks", 4'h7);
    end

    // Reset lands mid-debounce of an increment while blinking.
    btn = 4'b0001;
    @(posedge sclk);
    @(posedge sclk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 4'b0000);
    btn = 4'b0000;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (15) @(posedge sclk);
    #1;
    checkOutput("rst_no_pending", 4'b0000);
    applyStimulus(4'b0001, 3);
    checkOutput("rst_blink_cleared", 4'h1);

    @(negedge sclk);
    rst_n = 1'b0;
    btn   = 4'b0001;
    @(negedge sclk);
    #1;
    checkOutput("rst_held_btn", 4'b0000);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (12) @(posedge sclk);
    #1;
    checkOutput("held_through_reset", 4'h1);
    @(negedge sclk);
    btn = 4'b0000;
    repeat (10) @(posedge sclk);
    #1;
    checkOutput("held_through_reset_once", 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
